aes_128_pipe: RTL and testbench

AES_128_PIPE -- requirements
Module: aes_128_pipe

---
 rtl/aes_128_pipe.sv | 162 ++++++++++++++++
 tb/tb_aes_128_pipe.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_128_pipe.sv
// aes_128_pipe: fully pipelined AES-128 encryptor. It accepts one block per clock and has a latency of 21 cycles.
// Defining AES_128_PIPE_LFSR_EN sources the plaintext and key from internal LFSRs instead of the ports.
module aes_128_pipe (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] state,
  input  logic [127:0] key,
  input  logic         in_valid,
  output logic [127:0] out,
  output logic         out_valid
);
  localparam int unsigned BLK_W   = 128;
  localparam int unsigned ROUNDS  = 10;
  localparam int unsigned LATENCY = 2 * ROUNDS + 1;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] RCON [ROUNDS] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [7:0] xt(input logic [7:0] a);
    xt = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  logic [BLK_W-1:0] src_state;
  logic [BLK_W-1:0] src_key;

`ifdef AES_128_PIPE_LFSR_EN
  logic [BLK_W-1:0] st_lfsr_q, st_lfsr_d;
  logic [BLK_W-1:0] key_lfsr_q, key_lfsr_d;
  logic             unused_ports;

  assign st_lfsr_d  = {st_lfsr_q[126:0],
                       ~(st_lfsr_q[127] ^ st_lfsr_q[125] ^ st_lfsr_q[100] ^ st_lfsr_q[98])};
  assign key_lfsr_d = {key_lfsr_q[126:0],
                       ~(key_lfsr_q[127] ^ key_lfsr_q[125] ^ key_lfsr_q[100] ^ key_lfsr_q[98])};

  // The seeds form the first block; each accepted block advances both LFSRs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_lfsr_q  <= {4{32'hDEADBEEF}};
      key_lfsr_q <= {4{32'hCAFEFEED}};
    end else if (in_valid) begin
      st_lfsr_q  <= st_lfsr_d;
      key_lfsr_q <= key_lfsr_d;
    end
  end

  assign src_state    = st_lfsr_q;
  assign src_key      = key_lfsr_q;
  assign unused_ports = ^{state, key};
`else
  assign src_state = state;
  assign src_key   = key;
`endif

  logic [ROUNDS:0][BLK_W-1:0]   data_s;
  logic [ROUNDS-1:0][BLK_W-1:0] key_s;
  logic [BLK_W-1:0]             s0_data_d, s0_data_q, s0_key_q;
  logic [LATENCY-1:0]           vld_q;

  assign s0_data_d = src_state ^ src_key;

  // Stage 0: initial AddRoundKey; the key then travels alongside its block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_data_q <= '0;
      s0_key_q  <= '0;
      vld_q     <= '0;
    end else begin
      s0_data_q <= s0_data_d;
      s0_key_q  <= src_key;
      vld_q     <= {vld_q[LATENCY-2:0], in_valid};
    end
  end

  assign data_s[0] = s0_data_q;
  assign key_s[0]  = s0_key_q;

  for (genvar r = 1; r <= ROUNDS; r++) begin : g_round
    logic [BLK_W-1:0] kin, rk_d, rk_q, da_q, db_d, db_q;
    logic [31:0]      rot_w, sub_w, w0, w1, w2, w3;
    logic [15:0][7:0] sb, sr, mc;

    assign kin   = key_s[r-1];
    assign rot_w = {kin[23:0], kin[31:24]};
    for (genvar k = 0; k < 4; k++) begin : g_ksub
      assign sub_w[8*k +: 8] = SBOX[rot_w[8*k +: 8]];
    end
    assign w0   = kin[127:96] ^ sub_w ^ {RCON[r-1], 24'h000000};
    assign w1   = kin[95:64] ^ w0;
    assign w2   = kin[63:32] ^ w1;
    assign w3   = kin[31:0] ^ w2;
    assign rk_d = {w0, w1, w2, w3};

    // sb/sr/mc are indexed by FIPS byte number (row + 4*column).
    for (genvar i = 0; i < 16; i++) begin : g_sub
      assign sb[i] = SBOX[da_q[127-8*i -: 8]];
      assign db_d[127-8*i -: 8] = mc[i] ^ rk_q[127-8*i -: 8];
    end

    for (genvar c = 0; c < 4; c++) begin : g_col
      for (genvar w = 0; w < 4; w++) begin : g_row
        assign sr[w + 4*c] = sb[w + 4*((c + w) % 4)];
      end
      if (r == ROUNDS) begin : g_nomix
        assign mc[4*c +: 4] = sr[4*c +: 4];
      end else begin : g_mix
        assign mc[4*c]   = xt(sr[4*c]) ^ xt(sr[4*c+1]) ^ sr[4*c+1] ^ sr[4*c+2] ^ sr[4*c+3];
        assign mc[4*c+1] = sr[4*c] ^ xt(sr[4*c+1]) ^ xt(sr[4*c+2]) ^ sr[4*c+2] ^ sr[4*c+3];
        assign mc[4*c+2] = sr[4*c] ^ sr[4*c+1] ^ xt(sr[4*c+2]) ^ xt(sr[4*c+3]) ^ sr[4*c+3];
        assign mc[4*c+3] = xt(sr[4*c]) ^ sr[4*c] ^ sr[4*c+1] ^ sr[4*c+2] ^ xt(sr[4*c+3]);
      end
    end

    // First half registers the round key; second half registers the round transform.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rk_q <= '0;
        da_q <= '0;
        db_q <= '0;
      end else begin
        rk_q <= rk_d;
        da_q <= data_s[r-1];
        db_q <= db_d;
      end
    end

    assign data_s[r] = db_q;

    if (r < ROUNDS) begin : g_kpass
      logic [BLK_W-1:0] kb_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) kb_q <= '0;
        else        kb_q <= rk_q;
      end
      assign key_s[r] = kb_q;
    end
  end

  assign out       = data_s[ROUNDS];
  assign out_valid = vld_q[LATENCY-1];

endmodule

// File: tb/tb_aes_128_pipe.sv
// tb_aes_128_pipe: directed and streaming checks of aes_128_pipe against a byte-level AES-128 reference.
module tb_aes_128_pipe;
  localparam int unsigned LAT = 21;

  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] C0 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic         clk, rst_n, in_valid, out_valid;
  logic [127:0] state, key, out;

  int checks = 0;
  int errors = 0;
  int valid_seen = 0;

  logic [7:0] sb_t [256];

  aes_128_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .state     (state),
    .key       (key),
    .in_valid  (in_valid),
    .out       (out),
    .out_valid (out_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa, bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  // S-box from first principles: multiplicative inverse in GF(2^8) followed by the affine map.
  function automatic void build_sbox();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb_t[x] = s;
    end
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] k, input logic [127:0] p);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [31:0]  tmp;
    logic [7:0]   rc;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb_t[tmp[23:16]], sb_t[tmp[15:8]], sb_t[tmp[7:0]], sb_t[tmp[31:24]]} ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = p[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int i = 0; i < 16; i++) s[i] = sb_t[s[i]];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) t[r+4*c] = s[r + 4*((c+r)%4)];
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          s[r+4*c] = (rnd == 10) ? t[r+4*c]
                   : gmul(t[4*c+r], 8'h02) ^ gmul(t[4*c+(r+1)%4], 8'h03)
                     ^ t[4*c+(r+2)%4] ^ t[4*c+(r+3)%4];
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*rnd + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  typedef struct {
    bit           v;
    logic [127:0] d;
  } exp_t;

  exp_t exp_q [$];

  // Every edge: log what the DUT sampled, then check the entry from 20 edges earlier.
  always @(posedge clk) begin
    exp_t e, h;
    if (!rst_n) begin
      exp_q.delete();
      #1;
      chk("reset_out_valid", 128'(out_valid), 128'h0);
      chk("reset_out", out, 128'h0);
    end else begin
      e.v = in_valid;
      e.d = in_valid ? aes_ref(key, state) : 128'h0;
      exp_q.push_back(e);
      #1;
      if (exp_q.size() == LAT) begin
        h = exp_q.pop_front();
        chk("pipe_valid", 128'(out_valid), 128'(h.v));
        if (h.v) begin
          chk("pipe_data", out, h.d);
          valid_seen++;
        end
      end else begin
        chk("fill_valid", 128'(out_valid), 128'h0);
      end
    end
  end

  initial begin
    int base;
    rst_n = 1'b0; in_valid = 1'b0; state = '0; key = '0;
    build_sbox();
    chk("model_sbox_00", 128'(sb_t[0]), 128'h63);
    chk("model_sbox_53", 128'(sb_t[8'h53]), 128'hed);
    chk("model_vec_c1", aes_ref(K1, P1), C1);
    chk("model_vec_c2", aes_ref(K2, P2), C2);
    chk("model_vec_c0", aes_ref('0, '0), C0);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single block: valid for exactly one cycle, 21 cycles later.
    key = K1; state = P1; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; key = '0; state = '0;
    repeat (20) @(posedge clk);
    #1;
    chk("c1_valid", 128'(out_valid), 128'h1);
    chk("c1_data", out, C1);
    @(posedge clk);
    #1;
    chk("c1_one_cycle", 128'(out_valid), 128'h0);

    @(negedge clk);
    key = K2; state = P2; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; key = '0; state = '0;
    repeat (20) @(posedge clk);
    #1;
    chk("c2_valid", 128'(out_valid), 128'h1);
    chk("c2_data", out, C2);

    // Back-to-back blocks with different keys.
    @(negedge clk);
    key = '0; state = '0; in_valid = 1'b1;
    @(negedge clk);
    key = K1; state = P1;
    @(negedge clk);
    in_valid = 1'b0; key = '0; state = '0;
    repeat (19) @(posedge clk);
    #1;
    chk("b2b_first_valid", 128'(out_valid), 128'h1);
    chk("b2b_first_data", out, C0);
    @(posedge clk);
    #1;
    chk("b2b_second_valid", 128'(out_valid), 128'h1);
    chk("b2b_second_data", out, C1);

    // 100 random blocks streamed without gaps.
    @(negedge clk);
    base = valid_seen;
    for (int n = 0; n < 100; n++) begin
      key   = {$urandom, $urandom, $urandom, $urandom};
      state = {$urandom, $urandom, $urandom, $urandom};
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (25) @(negedge clk);
    chk("stream_count", 128'(valid_seen - base), 128'd100);

    // Reset with blocks in flight: outputs clear at once and nothing stale emerges.
    for (int n = 0; n < 15; n++) begin
      key   = {$urandom, $urandom, $urandom, $urandom};
      state = {$urandom, $urandom, $urandom, $urandom};
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    base = valid_seen;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out", out, 128'h0);
    chk("async_rst_valid", 128'(out_valid), 128'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("no_stale_after_rst", 128'(valid_seen - base), 128'd0);

    // The pipeline still works after the mid-stream reset.
    key = K2; state = P2; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (25) @(negedge clk);
    chk("post_rst_count", 128'(valid_seen - base), 128'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
